fc_layer: RTL and testbench

Parametrised int8 fully-connected layer engine for the PS/PL inference pipeline.
- Streams an activation vector from activation RAM and a weight matrix from weight ROM, performing one MAC per cycle.
- Applies per-neuron requantisation (zero-point correction, bias, Q31 multiplier, rounding, ReLU, saturation) and writes one int8 result per neuron to output RAM.
- Driven by a start/done handshake from the layer sequencer; sits between the conv/pool stages and the classifier output buffer.

---
 rtl/fc_pkg.sv | 12 +
 rtl/fc_requant.sv | 52 +++++
 rtl/fc_layer.sv | 178 +++++++++++++++++
 tb/tb_fc_layer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the int8 fully-connected layer engine.
package fc_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_MAC, S_DRAIN, S_RQ_SUM, S_RQ_MUL, S_RQ_OUT, S_WRITE, S_DONE
    } fc_state_e;

    localparam int QW_M   = 0;
    localparam int QW_ZC  = 1;
    localparam int QW_B   = 2;
    localparam int ACC_W  = 32;
    localparam int PROD_W = 64;
endpackage

// File: rtl/fc_requant.sv
// Three-stage requantiser: zero-point/bias correction, Q31 multiply, round + ReLU + saturate.
module fc_requant
    import fc_pkg::*;
#(
    parameter int OUT_ZP = -128,
    parameter bit RELU   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sum_en_i,
    input  logic                    mul_en_i,
    input  logic                    out_en_i,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [ACC_W-1:0] zc_i,
    input  logic signed [ACC_W-1:0] b_i,
    input  logic signed [ACC_W-1:0] m_i,
    output logic [7:0]              y_o
);
    logic signed [ACC_W-1:0] s_q;
    logic [ACC_W:0]          p_hi_q;   // product bits [63:31]; lower bits never affect the result
    logic signed [ACC_W:0]   r;
    logic signed [ACC_W+1:0] t;
    logic [7:0]              y_q, y_d;

    always_comb begin
        r   = $signed({p_hi_q[ACC_W], p_hi_q[ACC_W:1]}) + $signed({{ACC_W{1'b0}}, p_hi_q[0]});
        t   = $signed({r[ACC_W], r}) + $signed((ACC_W+2)'(OUT_ZP));
        y_d = t[7:0];
        if (RELU && (r[ACC_W] || (r == '0)))
            y_d = 8'(OUT_ZP);
        else if (t > 34'sd127)
            y_d = 8'h7F;
        else if (t < -34'sd128)
            y_d = 8'h80;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            p_hi_q <= '0;
            y_q    <= '0;
        end else begin
            if (sum_en_i) s_q <= acc_i - zc_i + b_i;
            if (mul_en_i)
                p_hi_q <= (ACC_W+1)'(({{ACC_W{s_q[ACC_W-1]}}, s_q} *
                                      {{ACC_W{m_i[ACC_W-1]}}, m_i}) >> (ACC_W-1));
            if (out_en_i) y_q <= y_d;
        end
    end

    assign y_o = y_q;
endmodule

// File: rtl/fc_layer.sv
// int8 fully-connected layer: streams activations/weights one MAC per cycle, requantises
// each neuron and writes one int8 result per neuron.
module fc_layer
    import fc_pkg::*;
#(
    parameter int IN_LEN   = 1600,
    parameter int OUT_LEN  = 12,
    parameter int ADDR_W   = 16,
    parameter int MEM_LAT  = 2,
    parameter int IN_BASE  = 0,
    parameter int W_BASE   = 2664,
    parameter int Q_BASE   = 108,
    parameter int OUT_BASE = 16'h8000,
    parameter int OUT_ZP   = -128,
    parameter bit RELU     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    act_en,
    output logic [ADDR_W-1:0]       act_addr,
    input  logic signed [7:0]       act_data,
    output logic                    wgt_en,
    output logic [ADDR_W-1:0]       wgt_addr,
    input  logic signed [7:0]       wgt_data,
    output logic                    q_en,
    output logic [8:0]              q_addr,
    input  logic signed [31:0]      q_data,
    output logic                    out_en,
    output logic                    out_we,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [7:0]              out_data
);
    localparam int K_W = $clog2(IN_LEN + MEM_LAT + 1) + 1;
    localparam int N_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

    fc_state_e               state_q, state_d;
    logic [K_W-1:0]          k_q;
    logic [N_W-1:0]          n_q;
    logic [ADDR_W-1:0]       w_off_q;
    logic [8:0]              q_off_q;
    logic signed [ACC_W-1:0] acc_q, m_q, zc_q, b_q;
    logic [MEM_LAT-1:0]      vld_pipe, qv_pipe;
    logic [1:0]              qi_pipe [MEM_LAT];
    logic signed [15:0]      prod;
    logic [7:0]              y;
    logic                    last_mac, last_drain, last_n, q_rd;

    assign prod       = 16'(act_data) * 16'(wgt_data);
    assign last_mac   = (k_q == K_W'(IN_LEN - 1));
    assign last_drain = (k_q == K_W'(MEM_LAT - 1));
    assign last_n     = (n_q == N_W'(OUT_LEN - 1));
    // Qparams ride the first three MAC cycles; IN_LEN >= 3 lets all of them land before RQ_SUM.
    assign q_rd       = (state_q == S_MAC) && (k_q < K_W'(3));

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        act_en   = 1'b0;
        act_addr = '0;
        wgt_en   = 1'b0;
        wgt_addr = '0;
        q_en     = 1'b0;
        q_addr   = '0;
        out_en   = 1'b0;
        out_we   = 1'b0;
        out_addr = '0;
        out_data = '0;
        case (state_q)
            S_IDLE: if (start) state_d = S_MAC;
            S_MAC: begin
                busy     = 1'b1;
                act_en   = 1'b1;
                wgt_en   = 1'b1;
                act_addr = ADDR_W'(IN_BASE) + ADDR_W'(k_q);
                wgt_addr = ADDR_W'(W_BASE) + w_off_q + ADDR_W'(k_q);
                if (q_rd) begin
                    q_en   = 1'b1;
                    q_addr = 9'(Q_BASE) + q_off_q + 9'(k_q);
                end
                if (last_mac) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (last_drain) state_d = S_RQ_SUM;
            end
            S_RQ_SUM: begin busy = 1'b1; state_d = S_RQ_MUL; end
            S_RQ_MUL: begin busy = 1'b1; state_d = S_RQ_OUT; end
            S_RQ_OUT: begin busy = 1'b1; state_d = S_WRITE;  end
            S_WRITE: begin
                busy     = 1'b1;
                out_en   = 1'b1;
                out_we   = 1'b1;
                out_addr = ADDR_W'(OUT_BASE) + ADDR_W'(n_q);
                out_data = y;
                state_d  = last_n ? S_DONE : S_MAC;
            end
            S_DONE: begin done = 1'b1; state_d = S_IDLE; end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            n_q      <= '0;
            w_off_q  <= '0;
            q_off_q  <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            zc_q     <= '0;
            b_q      <= '0;
            vld_pipe <= '0;
            qv_pipe  <= '0;
            for (int i = 0; i < MEM_LAT; i++) qi_pipe[i] <= '0;
        end else begin
            if (state_d != state_q)
                k_q <= '0;
            else if (state_q == S_MAC || state_q == S_DRAIN)
                k_q <= k_q + K_W'(1);

            if (state_q == S_WRITE && !last_n) begin
                n_q     <= n_q + N_W'(1);
                w_off_q <= w_off_q + ADDR_W'(IN_LEN);
                q_off_q <= q_off_q + 9'd3;
            end else if (state_q == S_DONE) begin
                n_q     <= '0;
                w_off_q <= '0;
                q_off_q <= '0;
            end

            // Read-return tags: bit MEM_LAT-1 marks the cycle the memory data is valid.
            vld_pipe[0] <= (state_q == S_MAC);
            qv_pipe[0]  <= q_rd;
            qi_pipe[0]  <= k_q[1:0];
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                qv_pipe[i]  <= qv_pipe[i-1];
                qi_pipe[i]  <= qi_pipe[i-1];
            end

            if (vld_pipe[MEM_LAT-1])
                acc_q <= acc_q + {{16{prod[15]}}, prod};
            else if (state_q == S_WRITE)
                acc_q <= '0;

            if (qv_pipe[MEM_LAT-1]) begin
                case (qi_pipe[MEM_LAT-1])
                    2'(QW_M):  m_q  <= q_data;
                    2'(QW_ZC): zc_q <= q_data;
                    2'(QW_B):  b_q  <= q_data;
                    default: ;
                endcase
            end
        end
    end

    fc_requant #(.OUT_ZP(OUT_ZP), .RELU(RELU)) u_requant (
        .clk      (clk),
        .rst_n    (rst_n),
        .sum_en_i (state_q == S_RQ_SUM),
        .mul_en_i (state_q == S_RQ_MUL),
        .out_en_i (state_q == S_RQ_OUT),
        .acc_i    (acc_q),
        .zc_i     (zc_q),
        .b_i      (b_q),
        .m_i      (m_q),
        .y_o      (y)
    );
endmodule

// File: tb/tb_fc_layer.sv
// Bench for fc_layer: two configurations (MEM_LAT=3 ReLU/ZP=-128, MEM_LAT=1 no ReLU/ZP=0)
// sharing one set of behavioural memories.
module tb_fc_layer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    always #5 clk = ~clk;

    logic busy_a, done_a, act_en_a, wgt_en_a, q_en_a, out_en_a, out_we_a;
    logic [15:0] act_addr_a, wgt_addr_a, out_addr_a;
    logic [8:0]  q_addr_a;
    logic [7:0]  out_data_a, act_data_a, wgt_data_a;
    logic [31:0] q_data_a;
    logic busy_b, done_b, act_en_b, wgt_en_b, q_en_b, out_en_b, out_we_b;
    logic [15:0] act_addr_b, wgt_addr_b, out_addr_b;
    logic [8:0]  q_addr_b;
    logic [7:0]  out_data_b, act_data_b, wgt_data_b;
    logic [31:0] q_data_b;

    fc_layer #(.IN_LEN(4), .OUT_LEN(2), .ADDR_W(16), .MEM_LAT(3), .IN_BASE(0), .W_BASE(16),
               .Q_BASE(8), .OUT_BASE(16'h8000), .OUT_ZP(-128), .RELU(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .act_en(act_en_a), .act_addr(act_addr_a), .act_data(act_data_a),
        .wgt_en(wgt_en_a), .wgt_addr(wgt_addr_a), .wgt_data(wgt_data_a),
        .q_en(q_en_a), .q_addr(q_addr_a), .q_data(q_data_a),
        .out_en(out_en_a), .out_we(out_we_a), .out_addr(out_addr_a), .out_data(out_data_a));

    fc_layer #(.IN_LEN(4), .OUT_LEN(2), .ADDR_W(16), .MEM_LAT(1), .IN_BASE(0), .W_BASE(16),
               .Q_BASE(8), .OUT_BASE(16'h8000), .OUT_ZP(0), .RELU(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .act_en(act_en_b), .act_addr(act_addr_b), .act_data(act_data_b),
        .wgt_en(wgt_en_b), .wgt_addr(wgt_addr_b), .wgt_data(wgt_data_b),
        .q_en(q_en_b), .q_addr(q_addr_b), .q_data(q_data_b),
        .out_en(out_en_b), .out_we(out_we_b), .out_addr(out_addr_b), .out_data(out_data_b));

    // Behavioural memories: data for an address presented in cycle k appears in cycle k+MEM_LAT.
    byte act_mem [256];
    byte wgt_mem [256];
    int  q_mem   [512];
    logic [15:0] apa [3], wpa [3], apb, wpb;
    logic [8:0]  qpa [3], qpb;

    always @(posedge clk) begin
        apa[0] <= act_addr_a; wpa[0] <= wgt_addr_a; qpa[0] <= q_addr_a;
        for (int i = 1; i < 3; i++) begin
            apa[i] <= apa[i-1]; wpa[i] <= wpa[i-1]; qpa[i] <= qpa[i-1];
        end
        apb <= act_addr_b; wpb <= wgt_addr_b; qpb <= q_addr_b;
    end
    assign act_data_a = act_mem[apa[2][7:0]];
    assign wgt_data_a = wgt_mem[wpa[2][7:0]];
    assign q_data_a   = q_mem[qpa[2]];
    assign act_data_b = act_mem[apb[7:0]];
    assign wgt_data_b = wgt_mem[wpb[7:0]];
    assign q_data_b   = q_mem[qpb];

    int errors = 0, checks = 0;
    int exp_a [2], exp_b [2];
    int wcnt_a = 0, wcnt_b = 0, base_a = 0, base_b = 0;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Neuron result straight from the arithmetic rules: dot product, correction, round-half-up
    // of s*M/2^32, optional ReLU, output zero point, int8 clamp.
    function automatic int model(input int n, input bit relu, input int zp);
        int acc, s;
        longint p, r;
        acc = 0;
        for (int k = 0; k < 4; k++) acc += int'(act_mem[k]) * int'(wgt_mem[16 + 4*n + k]);
        s = acc - q_mem[9 + 3*n] + q_mem[10 + 3*n];
        p = longint'(s) * longint'(q_mem[8 + 3*n]);
        r = (p + 64'sd2147483648) >>> 32;
        if (relu && r <= 0) return zp;
        r = r + zp;
        if (r > 127)  return 127;
        if (r < -128) return -128;
        return int'(r);
    endfunction

    task automatic load(input logic [3:0][7:0] a, input logic [3:0][7:0] w0,
                        input logic [3:0][7:0] w1,
                        input int m0, input int zc0, input int b0,
                        input int m1, input int zc1, input int b1);
        for (int k = 0; k < 4; k++) begin
            act_mem[k]      = a[k];
            wgt_mem[16 + k] = w0[k];
            wgt_mem[20 + k] = w1[k];
        end
        q_mem[8]  = m0; q_mem[9]  = zc0; q_mem[10] = b0;
        q_mem[11] = m1; q_mem[12] = zc1; q_mem[13] = b1;
        for (int n = 0; n < 2; n++) begin
            exp_a[n] = model(n, 1'b1, -128);
            exp_b[n] = model(n, 1'b0, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_en_a) begin
            if (wcnt_a - base_a > 1) chk("extra_write_a", wcnt_a - base_a, 1);
            else begin
                chk("wr_we_a", out_we_a, 1);
                chk("wr_addr_a", out_addr_a, 32768 + wcnt_a - base_a);
                chk("wr_data_a", $signed(out_data_a), exp_a[wcnt_a - base_a]);
            end
            wcnt_a++;
        end
        if (rst_n && out_en_b) begin
            if (wcnt_b - base_b > 1) chk("extra_write_b", wcnt_b - base_b, 1);
            else begin
                chk("wr_we_b", out_we_b, 1);
                chk("wr_addr_b", out_addr_b, 32768 + wcnt_b - base_b);
                chk("wr_data_b", $signed(out_data_b), exp_b[wcnt_b - base_b]);
            end
            wcnt_b++;
        end
    end

    task automatic run(input bit sel, input int exp_cyc);
        int cyc;
        bit fin;
        logic b, d;
        @(negedge clk);
        if (sel) begin start_b = 1'b1; base_b = wcnt_b; end
        else     begin start_a = 1'b1; base_a = wcnt_a; end
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            cyc++;
            b = sel ? busy_b : busy_a;
            d = sel ? done_b : done_a;
            if (cyc == 1) chk("busy_after_start", b, 1);
            if (cyc == 5) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            if (d) begin
                fin = 1'b1;
                chk("busy_low_at_done", b, 0);
            end
        end
        chk("done_latency", cyc, exp_cyc);
        chk("write_count", sel ? (wcnt_b - base_b) : (wcnt_a - base_a), 2);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctrl_a", {busy_a, done_a, act_en_a, wgt_en_a, q_en_a, out_en_a, out_we_a, out_addr_a}, 0);
        chk("rst_bus_a",  {act_addr_a, wgt_addr_a, q_addr_a, out_data_a}, 0);
        chk("rst_ctrl_b", {busy_b, done_b, act_en_b, wgt_en_b, q_en_b, out_en_b, out_we_b, out_addr_b}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        // Golden: acc0=10, acc1=-10 with M=0x7FFFFFFF.
        load({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, {4{8'hFF}},
             32'h7FFFFFFF, 0, 0, 32'h7FFFFFFF, 0, 0);
        chk("pin_gold0", exp_a[0], -123);
        chk("pin_gold1", exp_a[1], -128);
        run(1'b0, 23);

        // Rounding (acc=3, M=0x40000000) and saturation (acc=1000, M=0x7FFFFFFF).
        load({8'd100, 8'd1, 8'd1, 8'd1}, {8'd0, 8'd1, 8'd1, 8'd1}, {8'd10, 8'd0, 8'd0, 8'd0},
             32'h40000000, 0, 0, 32'h7FFFFFFF, 0, 0);
        chk("pin_round", exp_a[0], -127);
        chk("pin_sat", exp_a[1], 127);
        run(1'b0, 23);

        // No ReLU, zero point 0: acc=-10, then Zc=4/B=6 moves s to -8.
        load({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'hFF}}, {4{8'hFF}},
             32'h7FFFFFFF, 0, 0, 32'h7FFFFFFF, 4, 6);
        chk("pin_norelu0", exp_b[0], -5);
        chk("pin_norelu1", exp_b[1], -4);
        run(1'b1, 19);

        // Reset in the middle of neuron 1's MAC, then a clean rerun.
        load({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd1}}, {4{8'hFF}},
             32'h7FFFFFFF, 0, 0, 32'h7FFFFFFF, 0, 0);
        @(negedge clk);
        start_a = 1'b1;
        base_a = wcnt_a;
        repeat (13) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        chk("pre_reset_mac", act_en_a, 1);
        chk("pre_reset_writes", wcnt_a - base_a, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 23);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
